// File: rtl/fifo_uart_tx.sv
// Byte-FIFO-fed 8N1 serial transmitter; pulls one FIFO entry per frame and drives the TX pin.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and stop bit.
module fifo_uart_tx #(
  parameter int unsigned CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       fifo_not_empty,
  output logic       fifo_rd,
  input  logic [7:0] fifo_rdata,
  input  logic       fifo_rvalid,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] BaudReload = CntW'(CLK_DIV - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StFetch, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StFetch, StStart, StData, StStop} state_e;
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            baud_tick;
`ifdef FIFO_UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  assign baud_tick = (baud_q == '0);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    done_d  = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    fifo_rd = (state_q == StIdle) & enable & fifo_not_empty & rst_n;

    unique case (state_q)
      StIdle: begin
        txd_d = 1'b1;
        if (fifo_rd) state_d = StFetch;
      end
      StFetch: begin
        // rvalid low means the FIFO emptied underneath us; give up quietly
        if (fifo_rvalid) begin
          shift_d = fifo_rdata;
          baud_d  = BaudReload;
          bit_d   = 3'd0;
          txd_d   = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_d = ^fifo_rdata;
`endif
          state_d = StStart;
        end else begin
          state_d = StIdle;
        end
      end
      StStart: begin
        if (baud_tick) begin
          baud_d  = BaudReload;
          txd_d   = shift_q[0];
          state_d = StData;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      StData: begin
        if (baud_tick) begin
          baud_d = BaudReload;
          if (bit_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
            txd_d   = parity_q;
            state_d = StParity;
`else
            txd_d   = 1'b1;
            state_d = StStop;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      StParity: begin
        if (baud_tick) begin
          baud_d  = BaudReload;
          txd_d   = 1'b1;
          state_d = StStop;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
`endif
      StStop: begin
        if (baud_tick) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
